// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: self-timed POP/PUSH rr microsequencer driven by an internal M-cycle/T-step counter.
// PUSH support is compiled in only when STACK_SEQ_PUSH_EN is defined.
module stack_op_sequencer #(
    parameter int NUM_PAIRS = 4,
    parameter int STEPS     = 4
) (
    input  logic                         i_Clk,
    input  logic                         i_Reset_n,
    input  logic                         i_Start,
    input  logic                         i_Op,
    input  logic [$clog2(NUM_PAIRS)-1:0] i_Pair,
    input  logic                         i_Wait,
    output logic                         o_Busy,
    output logic                         o_Done,
    output logic                         o_IR_Fetch,
    output logic [2*NUM_PAIRS-1:0]       o_Write8,
    output logic [2*NUM_PAIRS-1:0]       o_Read8,
    output logic [1:0]                   o_WriteALU8,
    output logic                         o_Address_Out,
    output logic                         o_Bus_In,
    output logic                         o_Bus_Out,
    output logic                         o_SP_Inc,
    output logic                         o_SP_Dec
);
    localparam int PW = $clog2(NUM_PAIRS);
    localparam int SW = $clog2(STEPS);
    localparam int W8 = 2 * NUM_PAIRS;
    localparam logic [PW:0] NPW = (PW + 1)'(NUM_PAIRS);
`ifdef STACK_SEQ_PUSH_EN
    localparam logic PUSH_OK = 1'b1;
`else
    localparam logic PUSH_OK = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          state, state_nx;
    logic            op_q, op_nx;
    logic [PW-1:0]   pair_q, pair_nx;
    logic [1:0]      m_q, m_nx;
    logic [SW-1:0]   step_q, step_nx;
    logic            run, go, s1, sl, last_m, last_step, pop, valid, af, xfer;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state  <= S_IDLE;
            op_q   <= 1'b0;
            pair_q <= '0;
            m_q    <= '0;
            step_q <= '0;
        end else begin
            state  <= state_nx;
            op_q   <= op_nx;
            pair_q <= pair_nx;
            m_q    <= m_nx;
            step_q <= step_nx;
        end
    end

    assign last_m    = m_q == (op_q ? 2'd3 : 2'd2);
    assign last_step = step_q == SW'(STEPS - 1);

    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        pair_nx  = pair_q;
        m_nx     = m_q;
        step_nx  = step_q;
        if (state == S_IDLE) begin
            if (i_Start && (PUSH_OK || !i_Op)) begin
                state_nx = S_RUN;
                op_nx    = i_Op;
                pair_nx  = i_Pair;
                m_nx     = '0;
                step_nx  = '0;
            end
        end else if (!i_Wait) begin
            step_nx = last_step ? '0 : step_q + SW'(1);
            m_nx    = last_step ? m_q + 2'd1 : m_q;
            if (last_step && last_m) state_nx = S_IDLE;
        end
    end

    // Strobes qualify on ~i_Wait so a stalled step never repeats them.
    assign run   = state == S_RUN;
    assign go    = run & ~i_Wait;
    assign s1    = go & (step_q == SW'(1));
    assign sl    = go & last_step;
    assign pop   = ~op_q;
    assign valid = {1'b0, pair_q} < NPW;
    assign af    = pair_q == PW'(NUM_PAIRS - 1);
    assign xfer  = sl & pop & ~last_m;

    assign o_Busy        = run;
    assign o_IR_Fetch    = run & last_m;
    assign o_Done        = o_IR_Fetch & sl;
    assign o_Address_Out = s1 & ~last_m & (pop | (m_q != 2'd0));
    assign o_SP_Inc      = s1 & pop & ~last_m;
    assign o_Bus_In      = xfer;
    assign o_Write8      = (xfer & valid & ~af) ? W8'(1) << {pair_q, m_q[0]} : '0;
    assign o_WriteALU8   = (xfer & af) ? (m_q[0] ? 2'b10 : 2'b01) : 2'b00;

`ifdef STACK_SEQ_PUSH_EN
    logic push_out;
    assign push_out  = op_q & sl & ((m_q == 2'd1) | (m_q == 2'd2));
    assign o_Bus_Out = push_out;
    assign o_SP_Dec  = op_q & ((s1 & (m_q == 2'd0)) | (sl & (m_q == 2'd1)));
    assign o_Read8   = (push_out & valid) ? W8'(1) << {pair_q, m_q == 2'd1} : '0;
`else
    assign o_Bus_Out = 1'b0;
    assign o_SP_Dec  = 1'b0;
    assign o_Read8   = '0;
`endif
endmodule

// File: doc/stack_op_sequencer.md
# stack_op_sequencer

Parametrised stack-operation microsequencer for the CPU control unit. It executes POP rr and PUSH rr as self-timed multi-M-cycle sequences from an internal M-cycle/T-step counter, rather than decoding externally supplied cycle counts. It drives the same register-file, ALU-register, bus and 16-bit incrementer strobes as the other microcode blocks. It generalises the fixed 4-pair, 4-step stack decode to configurable pair count and T-steps per M-cycle, and adds memory-wait stalling and PUSH support.

## Interface
- NUM_PAIRS, 4: register pairs addressable; index NUM_PAIRS-1 is the flags pair (AF), where the low byte routes through the ALU flag path.
- STEPS, 4: T-steps per M-cycle, minimum 3.
- i_Clk  in  1  clock.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Start  in  1  request pulse; accepted only while o_Busy=0.
- i_Op  in  1  0=POP, 1=PUSH; sampled with i_Start.
- i_Pair  in  $clog2(NUM_PAIRS)  pair index; sampled with i_Start.
- i_Wait  in  1  memory not ready; freezes the step counter.
- o_Busy  out  1  sequence in progress.
- o_Done  out  1  one-cycle pulse on the final step of the fetch M-cycle.
- o_IR_Fetch  out  1  high for the whole fetch M-cycle.
- o_Write8  out  2*NUM_PAIRS  one-hot register write strobe; bit 2p = low byte of pair p, bit 2p+1 = high byte.
- o_Read8  out  2*NUM_PAIRS  one-hot register read select; same bit mapping.
- o_WriteALU8  out  2  {high, low} write strobes for the flags pair.
- o_Address_Out  out  1  SP is driven onto the address bus.
- o_Bus_In / o_Bus_Out  out  1 each  data-bus direction strobes.
- o_SP_Inc / o_SP_Dec  out  1 each  16-bit SP incrementer strobes.

## Operation
- Registered state: op, pair, M-cycle index (0..3), step (0..STEPS-1). All outputs are combinational decodes of this registered state.
- Every strobe is gated by ~i_Wait, so each strobe fires exactly once per step.
- Accept: when idle and i_Start=1, latch i_Op and i_Pair; the next cycle is M1 step 0.
- Step advance: step increments when i_Wait=0. On reaching STEPS-1 it wraps to 0 and the M-cycle index increments.
- POP p (3 M-cycles):
  - M1 step 1: o_Address_Out and o_SP_Inc.
  - M1 step STEPS-1: o_Bus_In, plus o_Write8[2p] (o_WriteALU8[0] if p=NUM_PAIRS-1).
  - M2: same as M1, targeting the high byte (bit 2p+1 / o_WriteALU8[1]).
  - M3: fetch.
- PUSH p (4 M-cycles):
  - M1 step 1: o_SP_Dec.
  - M2: o_Address_Out on step 1; on step STEPS-1, o_Bus_Out, o_Read8[2p+1] and o_SP_Dec.
  - M3: o_Address_Out on step 1; on step STEPS-1, o_Bus_Out and o_Read8[2p].
  - M4: fetch.
- Fetch M-cycle: o_IR_Fetch=1 throughout; o_Done on its last step. The block then returns to idle.
- i_Start while busy is ignored; no queueing.
- i_Pair >= NUM_PAIRS (non-power-of-2 NUM_PAIRS only): the request is treated as a no-op sequence with no write or read strobes, but still runs through fetch.

## Timing
- Reset (async assert, sync release): idle, o_Busy=0, and every other output 0.
- Latency with i_Wait=0: POP o_Done occurs 3*STEPS cycles after the accept edge; PUSH occurs 4*STEPS cycles after it.
- o_Busy rises the cycle after accept and falls the cycle after o_Done.
- A new i_Start may coincide with o_Done; it is ignored. Accept only happens when o_Busy=0.
- i_Wait stalls inflate latency by exactly the number of stalled cycles. Decodes stay held and strobes stay low while stalled.
- i_Wait during idle has no effect.
- Reset mid-sequence: all outputs drop to 0 immediately. No partial write strobe is issued after release.

## Configuration
- STACK_SEQ_PUSH_EN defined: PUSH is supported as specified above.
- STACK_SEQ_PUSH_EN undefined:
  - PUSH logic and o_Read8/o_Bus_Out/o_SP_Dec drivers are removed; those outputs are tied 0.
  - An i_Start with i_Op=1 is dropped: o_Busy stays 0 and no sequence runs.

## Test plan
- Reset, then POP pair 1 (NUM_PAIRS=4, STEPS=4, no wait):
  - o_SP_Inc pulses at cycles 2 and 6.
  - o_Write8=8'h04 at cycle 4 and 8'h08 at cycle 8.
  - o_IR_Fetch spans cycles 9-12 and o_Done occurs at cycle 12 (cycle 1 = first cycle after accept).
- POP pair 3 -> o_WriteALU8=2'b01 then 2'b10; o_Write8 stays 0 throughout.
- PUSH pair 2 -> o_SP_Dec at cycles 2 and 8; o_Read8=8'h20 with o_Bus_Out at cycle 8; 8'h10 at cycle 12; o_Done at cycle 16.
- Hold i_Wait=1 for 3 cycles on M1 step 3 of a POP -> o_Write8 pulses exactly once; o_Done is delayed by 3 cycles.
- Assert i_Reset_n=0 mid-PUSH M2 -> all outputs 0 immediately. After release, o_Busy stays 0 until the next i_Start; a second i_Start while busy is ignored.
- Build without STACK_SEQ_PUSH_EN, i_Start with i_Op=1 -> o_Busy never rises and all strobes stay 0.
